controle_enchimento: RTL and testbench
======================================

// Module: controle_enchimento
// PURPOSE
//   Automatic fill sequencer for the tank inlet valve. Debounces the low/high level
//   sensors and runs the fill cycle FSM. Emits one-cycle abre_auto/fecha_auto pulses
//   that wire directly into the valve block's auto inputs. Tracks manual mode so that
//   automatic control resumes from a known closed state. Flags sensor faults.
// PARAMETERS
//   DEB_CICLOS     4     consecutive stable cycles before a filtered sensor changes (>=1)
//   T_MIN_FECHADO  16    cycles the valve stays closed (PAUSA) before a new fill (>=1)
//   T_MAX_ENCHE    1024  max cycles in ENCHENDO before timeout fault (CONTROLE_TIMEOUT_EN only)
//   W              16    width of the shared cycle counter; must hold max(T_MIN_FECHADO, T_MAX_ENCHE)
// PORTS
//   clock        in   1  system clock, rising edge
//   reset_n      in   1  asynchronous reset, active low
//   manual       in   1  manual mode; same signal that drives the valve block
//   nivel_baixo  in   1  raw low sensor, 1 = water at/above low mark
//   nivel_alto   in   1  raw high sensor, 1 = water at/above high mark
//   limpa_falha  in   1  level: clears FALHA
//   abre_auto    out  1  1-cycle pulse: open valve
//   fecha_auto   out  1  1-cycle pulse: close valve
//   enchendo     out  1  1 while state == ENCHENDO
//   falha        out  1  1 while state == FALHA
//   db_estado    out  3  current state encoding (debug)
// BEHAVIOUR
//   - Reset (async, reset_n=0): state=PAUSA, counter=0, both filtered sensors=0,
//     filter counters=0, all outputs 0, db_estado=3'd2.
//   - Filter: per sensor, when raw != filtered for DEB_CICLOS consecutive cycles,
//     filtered<=raw. Any cycle with raw==filtered resets that sensor's filter counter.
//     The FSM uses filtered values only (fb, fa).
//   - States: ESPERA=0, ENCHENDO=1, PAUSA=2, MANUAL=3, FALHA=4. Codes 5-7 go to FALHA
//     with a fecha_auto pulse.
//   - Priority each cycle: FALHA hold > manual > sensor fault > normal transitions.
//   - Sensor fault: fa=1 while fb=0, in any state except FALHA/MANUAL: go to FALHA
//     and pulse fecha_auto.
//   - ESPERA: fb=0 -> ENCHENDO, pulse abre_auto, counter<=0.
//   - ENCHENDO: counter++ each cycle. fa=1 -> PAUSA, pulse fecha_auto, counter<=0.
//   - PAUSA: counter++. When counter==T_MIN_FECHADO-1 -> ESPERA. PAUSA therefore
//     lasts exactly T_MIN_FECHADO cycles.
//   - MANUAL: entered from ESPERA/ENCHENDO/PAUSA whenever manual=1; no pulses.
//     When manual=0 -> PAUSA, pulse fecha_auto once, counter<=0.
//   - FALHA: ignores manual and sensors. The valve block still obeys manual.
//     limpa_falha=1 -> PAUSA, counter<=0, no pulse.
//   - Pulse timing: pulses are registered and high in the cycle after the
//     transitioning edge, for exactly one cycle. abre_auto and fecha_auto are
//     never high together.
//   - Counter saturates at all-ones and never wraps.
// CONFIGURATION
//   CONTROLE_TIMEOUT_EN defined: in ENCHENDO, counter==T_MAX_ENCHE-1 with fa=0
//     -> FALHA, pulse fecha_auto. If fa=1 in the same cycle, the normal fill end
//     (PAUSA) wins.
//   Not defined: no fill timeout; ENCHENDO ends only via fa, manual or sensor fault.
// TESTING (DEB_CICLOS=4, T_MIN_FECHADO=16, T_MAX_ENCHE=64)
//   1 Reset, then hold nivel_baixo=0, nivel_alto=0 -> PAUSA 16 cycles, then ESPERA.
//     abre_auto pulses once; enchendo=1 afterwards.
//   2 While filling, raise nivel_baixo, then nivel_alto=1 for 4 cycles -> fecha_auto
//     pulses once, state=PAUSA; nivel_alto=1 for only 3 cycles -> no change.
//   3 manual=1 mid-fill -> db_estado=3, no pulses. manual=0 -> one fecha_auto,
//     PAUSA, refill after 16 cycles.
//   4 nivel_alto=1 with nivel_baixo=0 stable 4 cycles -> FALHA, fecha_auto pulses;
//     limpa_falha=1 -> PAUSA.
//   5 CONTROLE_TIMEOUT_EN, sensors stuck at 0 during fill -> FALHA 64 cycles after
//     abre_auto; without the macro -> stays in ENCHENDO.
//   6 Assert reset_n=0 mid-fill -> outputs 0 immediately (async); release -> PAUSA.

Source files
------------

// File: rtl/controle_enchimento_if.sv
// Signal bundle between the fill sequencer and its environment (level sensors,
// manual selector, fault clear in; valve pulses and status out).
interface controle_enchimento_if;
    logic       manual;
    logic       nivel_baixo;
    logic       nivel_alto;
    logic       limpa_falha;
    logic       abre_auto;
    logic       fecha_auto;
    logic       enchendo;
    logic       falha;
    logic [2:0] db_estado;

    modport master (
        output manual, nivel_baixo, nivel_alto, limpa_falha,
        input  abre_auto, fecha_auto, enchendo, falha, db_estado
    );

    modport slave (
        input  manual, nivel_baixo, nivel_alto, limpa_falha,
        output abre_auto, fecha_auto, enchendo, falha, db_estado
    );
endinterface

// File: rtl/controle_enchimento.sv
// Tank fill sequencer: debounces the level sensors and drives one-cycle open/close
// pulses into the valve block. Define CONTROLE_TIMEOUT_EN to add the fill timeout fault.
module controle_enchimento #(
    parameter int unsigned DEB_CICLOS    = 4,
    parameter int unsigned T_MIN_FECHADO = 16,
    parameter int unsigned T_MAX_ENCHE   = 1024,
    parameter int unsigned W             = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    controle_enchimento_if.slave   bus
);
    localparam int unsigned DW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
    localparam logic [DW-1:0] DEB_LIM   = DW'(DEB_CICLOS - 1);
    localparam logic [W-1:0]  PAUSA_LIM = W'(T_MIN_FECHADO - 1);
    localparam logic [W-1:0]  ENCHE_LIM = W'(T_MAX_ENCHE - 1);
`ifdef CONTROLE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [2:0] ESPERA   = 3'd0;
    localparam logic [2:0] ENCHENDO = 3'd1;
    localparam logic [2:0] PAUSA    = 3'd2;
    localparam logic [2:0] MANUAL   = 3'd3;
    localparam logic [2:0] FALHA    = 3'd4;

    // bit 0 = low sensor, bit 1 = high sensor
    logic [1:0]         raw;
    logic [1:0]         filt;
    logic [1:0][DW-1:0] deb_cnt;
    logic               fb;
    logic               fa;

    assign raw = {bus.nivel_alto, bus.nivel_baixo};
    assign fb  = filt[0];
    assign fa  = filt[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt    <= '0;
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LIM) begin
                    filt[i]    <= raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [2:0]   st, st_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic         abre_q, fecha_q, abre_nxt, fecha_nxt;

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = (&cnt) ? cnt : cnt + W'(1);
        abre_nxt  = 1'b0;
        fecha_nxt = 1'b0;
        if (st == FALHA) begin
            if (bus.limpa_falha) begin
                st_nxt  = PAUSA;
                cnt_nxt = '0;
            end
        end else if (st > FALHA) begin
            st_nxt    = FALHA;
            fecha_nxt = 1'b1;
        end else if (bus.manual) begin
            st_nxt = MANUAL;
        end else if (st == MANUAL) begin
            // leaving manual: force the valve closed so auto control restarts known
            st_nxt    = PAUSA;
            fecha_nxt = 1'b1;
            cnt_nxt   = '0;
        end else if (fa && !fb) begin
            st_nxt    = FALHA;
            fecha_nxt = 1'b1;
        end else begin
            case (st)
                ESPERA: begin
                    if (!fb) begin
                        st_nxt   = ENCHENDO;
                        abre_nxt = 1'b1;
                        cnt_nxt  = '0;
                    end
                end
                ENCHENDO: begin
                    if (fa) begin
                        st_nxt    = PAUSA;
                        fecha_nxt = 1'b1;
                        cnt_nxt   = '0;
                    end else if (TMO_EN && cnt == ENCHE_LIM) begin
                        st_nxt    = FALHA;
                        fecha_nxt = 1'b1;
                    end
                end
                PAUSA: begin
                    if (cnt == PAUSA_LIM) st_nxt = ESPERA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st      <= PAUSA;
            cnt     <= '0;
            abre_q  <= 1'b0;
            fecha_q <= 1'b0;
        end else begin
            st      <= st_nxt;
            cnt     <= cnt_nxt;
            abre_q  <= abre_nxt;
            fecha_q <= fecha_nxt;
        end
    end

    assign bus.abre_auto  = abre_q;
    assign bus.fecha_auto = fecha_q;
    assign bus.enchendo   = (st == ENCHENDO);
    assign bus.falha      = (st == FALHA);
    assign bus.db_estado  = st;
endmodule

// File: tb/tb_controle_enchimento.sv
// Scoreboard bench for controle_enchimento: a time-based reference model predicts
// state and valve pulses; a negedge monitor compares them against the DUT.
module tb_controle_enchimento;
    localparam int DEB  = 4;
    localparam int TMIN = 16;
    localparam int TMAX = 64;
`ifdef CONTROLE_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    controle_enchimento_if bus ();

    controle_enchimento #(
        .DEB_CICLOS(DEB), .T_MIN_FECHADO(TMIN), .T_MAX_ENCHE(TMAX), .W(16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef enum logic [2:0] {
        S_ESPERA = 3'd0, S_ENCHENDO = 3'd1, S_PAUSA = 3'd2, S_MANUAL = 3'd3, S_FALHA = 3'd4
    } st_t;

    typedef struct {
        bit          abre;
        int unsigned cyc;
    } pulse_t;

    pulse_t      exp_q[$];
    st_t         m_st  = S_PAUSA;
    int unsigned cyc   = 0;
    int unsigned enter = 0;
    bit [1:0]    m_filt = '0;
    int unsigned agree[2] = '{0, 0};
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, expv, cyc, $time);
        end
    endtask

    // Reference model: states by name, dwell times measured as elapsed edges,
    // a sensor flips once it has disagreed with its filtered value for DEB edges.
    initial begin
        st_t      nx;
        bit       pa, pf, fb, fa;
        bit [1:0] raw;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_st   = S_PAUSA;
                cyc    = 0;
                enter  = 0;
                m_filt = '0;
                agree  = '{0, 0};
                exp_q.delete();
            end else begin
                cyc++;
                fb = m_filt[0];
                fa = m_filt[1];
                nx = m_st;
                pa = 1'b0;
                pf = 1'b0;
                if (m_st == S_FALHA) begin
                    if (bus.limpa_falha) nx = S_PAUSA;
                end else if (bus.manual) begin
                    nx = S_MANUAL;
                end else if (m_st == S_MANUAL) begin
                    nx = S_PAUSA; pf = 1'b1;
                end else if (fa && !fb) begin
                    nx = S_FALHA; pf = 1'b1;
                end else if (m_st == S_ESPERA) begin
                    if (!fb) begin nx = S_ENCHENDO; pa = 1'b1; end
                end else if (m_st == S_ENCHENDO) begin
                    if (fa) begin
                        nx = S_PAUSA; pf = 1'b1;
                    end else if (TMO && (cyc - enter == TMAX)) begin
                        nx = S_FALHA; pf = 1'b1;
                    end
                end else if (m_st == S_PAUSA) begin
                    if (cyc - enter == TMIN) nx = S_ESPERA;
                end
                if (nx != m_st) enter = cyc;
                if (pa) exp_q.push_back('{abre: 1'b1, cyc: cyc});
                if (pf) exp_q.push_back('{abre: 1'b0, cyc: cyc});
                m_st = nx;
                raw = {bus.nivel_alto, bus.nivel_baixo};
                for (int i = 0; i < 2; i++) begin
                    if (raw[i] == m_filt[i]) begin
                        agree[i] = cyc;
                    end else if (cyc - agree[i] == DEB) begin
                        m_filt[i] = raw[i];
                        agree[i]  = cyc;
                    end
                end
            end
        end
    end

    // Monitor: state every cycle, pulses popped from the scoreboard when presented.
    initial begin
        pulse_t e;
        forever begin
            @(negedge clock);
            chk("db_estado", int'(bus.db_estado), int'(m_st));
            chk("enchendo", int'(bus.enchendo), int'(m_st == S_ENCHENDO));
            chk("falha", int'(bus.falha), int'(m_st == S_FALHA));
            if (bus.abre_auto && bus.fecha_auto) begin
                n_cmp++; n_err++;
                $display("FAIL pulse_both: abre_auto and fecha_auto high together (cycle %0d)", cyc);
            end
            if (bus.abre_auto || bus.fecha_auto) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL pulse_unexpected: abre=%0b fecha=%0b, none expected (cycle %0d)",
                             bus.abre_auto, bus.fecha_auto, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_abre", int'(bus.abre_auto), int'(e.abre));
                    chk("pulse_cycle", int'(cyc), int'(e.cyc));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++; n_err++;
                $display("FAIL pulse_missing: expected %s pulse at cycle %0d, got none",
                         e.abre ? "abre" : "fecha", e.cyc);
            end
        end
    end

    task automatic step(input bit m, input bit b, input bit a, input bit l, input int n);
        bus.manual      = m;
        bus.nivel_baixo = b;
        bus.nivel_alto  = a;
        bus.limpa_falha = l;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        bus.manual = 1'b0; bus.nivel_baixo = 1'b0; bus.nivel_alto = 1'b0; bus.limpa_falha = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_db_estado", int'(bus.db_estado), 2);
        chk("reset_abre", int'(bus.abre_auto), 0);
        chk("reset_fecha", int'(bus.fecha_auto), 0);
        reset_n = 1'b1;
        // empty tank: PAUSA, ESPERA, fill
        step(0, 0, 0, 0, 30);
        // low mark reached, short high glitch ignored, then real high -> PAUSA
        step(0, 1, 0, 0, 6);
        step(0, 1, 1, 0, 3);
        step(0, 1, 0, 0, 5);
        step(0, 1, 1, 0, 6);
        step(0, 1, 1, 0, 20);
        // drain, refill, manual interlude
        step(0, 0, 0, 0, 10);
        step(1, 0, 0, 0, 10);
        step(0, 0, 0, 0, 25);
        // high without low -> sensor fault, then clear
        step(0, 0, 1, 0, 6);
        step(0, 0, 0, 0, 5);
        step(0, 0, 0, 1, 2);
        // stuck-low sensors through a long fill (timeout only when enabled)
        step(0, 0, 0, 0, 100);
        // async reset in the middle of a fill
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 24);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_abre", int'(bus.abre_auto), 0);
        chk("async_rst_fecha", int'(bus.fecha_auto), 0);
        chk("async_rst_enchendo", int'(bus.enchendo), 0);
        chk("async_rst_falha", int'(bus.falha), 0);
        chk("async_rst_db_estado", int'(bus.db_estado), 2);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        // random sensor/manual/clear activity with durations around the debounce length
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(1, 7)));
        end
        step(0, 1, 0, 1, 40);
        chk("pending_pulses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
